updown_counter: RTL and testbench
=================================

// Module: updown_counter
// PURPOSE
//   Loadable, synchronous, modulo-2^WIDTH up/down counter.
//   Each rising clock edge does one of three things: loads a parallel value,
//   increments or decrements. It is a general-purpose sequential building
//   block for timers, address stepping and event counting.
// PARAMETERS
//   WIDTH  4  counter and load-data width in bits; count wraps modulo 2^WIDTH
// PORTS
//   clk    in   1      single clock; all state updates on the rising edge
//   rst    in   1      reset, asynchronous, active-low (0 = reset)
//   load   in   1      1 = parallel load of a on the next rising edge
//   mode   in   1      direction when not loading: 0 = up, 1 = down
//   a      in   WIDTH  parallel load value
//   count  out  WIDTH  registered counter value
// BEHAVIOUR
//   - Interface (decided): one clock, clk; asynchronous active-low reset, rst.
//   - Reset: while rst==0, count is forced to 0 immediately, with no clock
//     edge needed. Reset dominates all other inputs.
//   - Counting resumes on the first rising clk edge after rst returns to 1.
//   - Reset applied mid-count clears count at once; the prior value is lost.
//   - Priority on each rising clk edge with rst==1:
//       1. load==1            -> count <= a  (mode is ignored)
//       2. load==0, mode==0   -> count <= count + 1
//       3. load==0, mode==1   -> count <= count - 1
//   - There is no hold/enable state: with rst==1 the counter changes on every
//     edge.
//   - Wrap-around: up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1.
//     No saturation and no carry/borrow output.
//   - Latency: one cycle. A loaded value appears on count right after the
//     edge that sampled load==1.
//   - The next step counts from the loaded value in the direction of mode at
//     that edge.
//   - Inputs are sampled only at rising edges; changes between edges have no
//     effect.
//   - count is driven directly from the register; no combinational path runs
//     from the inputs to count.
//   - Arithmetic is unsigned, WIDTH bits, and the result is truncated to
//     WIDTH.
// STRUCTURE
//   - Shared package: localparams MODE_UP = 1'b0 and MODE_DOWN = 1'b1, plus
//     the default counter width constant.
//   - Single always block with asynchronous reset; no sub-module needed.
//   - The next-value mux (load / +1 / -1) is inline combinational logic
//     feeding the register.
// TESTING
//   (WIDTH = 4, 10 ns clock)
//   1. Reset: rst=0 at t=0 with other inputs X/0
//        -> count==0 before any clk edge.
//      Release rst=1 -> count stays 0 until the first edge.
//   2. Load then count up: load=1, mode=0, a=0 for one edge -> count==0.
//      Then load=0, mode=0, a=7 -> count 1,2,3,...,15,0,1
//        (wraps 15->0; a is ignored).
//   3. Load then count down: load=1, mode=1, a=14 -> count==14.
//      Then load=0, mode=1 -> 13,12,...,0,15,14 (wraps 0->15).
//   4. Load priority: load=1, mode=1, a=9 while counting up from 3
//        -> count==9 on the next edge, not 2 or 4.
//   5. Async reset mid-count: count==6 counting up; drop rst to 0 midway
//      between edges -> count==0 immediately.
//      Hold rst=0 across two edges -> count stays 0.
//      Release -> next edge gives 1.
//   6. Direction change: counting up at 5, switch mode to 1 with load=0
//        -> next edges give 4, 3; switching mode back to 0 -> 4.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down counter.
//   MODE_UP / MODE_DOWN : encodings of the mode input
//   DEFAULT_WIDTH       : default counter width in bits
package updown_counter_pkg;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/updown_counter.sv
// Loadable modulo-2^WIDTH up/down counter.
// Every rising clk edge with rst==1 either loads a, increments or decrements.
// Ports:
//   clk   : clock, rising-edge active
//   rst   : asynchronous active-low reset (0 clears count immediately)
//   load  : 1 = load a on the next edge (mode ignored)
//   mode  : direction when not loading (MODE_UP / MODE_DOWN)
//   a     : parallel load value
//   count : registered counter value
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-value mux; +/-1 truncates to WIDTH, giving the wrap-around.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = a;
        end else if (mode == MODE_DOWN) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (WIDTH = 4, 10 ns clock).
module tb_updown_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic       mode;
    logic [3:0] a;
    logic [3:0] count;

    int total;
    int bad;

    updown_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .mode  (mode),
        .a     (a),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        load = 1'b0;
        mode = 1'b0;
        a    = 'x;
        #1;
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("FAIL reset_before_edge: got %0d want 0", count);
        end
        #2;
        rst = 1'b1;
        a   = 4'd0;
        #1;
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("FAIL reset_released_no_edge: got %0d want 0", count);
        end
    endtask

    task automatic test_count_up();
        logic [3:0] exp;
        @(negedge clk);
        load = 1'b1; mode = 1'b0; a = 4'd0;
        step();
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("FAIL up_load0: got %0d want 0", count);
        end
        @(negedge clk);
        load = 1'b0; mode = 1'b0; a = 4'd7;
        for (int i = 0; i < 17; i++) begin
            exp = 4'((i + 1) % 16);
            step();
            total++;
            if (count !== exp) begin
                bad++;
                $display("FAIL up_step%0d: got %0d want %0d", i, count, exp);
            end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] exp;
        @(negedge clk);
        load = 1'b1; mode = 1'b1; a = 4'd14;
        step();
        total++;
        if (count !== 4'd14) begin
            bad++;
            $display("FAIL down_load14: got %0d want 14", count);
        end
        @(negedge clk);
        load = 1'b0; mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = 4'((13 - i + 16) % 16);
            step();
            total++;
            if (count !== exp) begin
                bad++;
                $display("FAIL down_step%0d: got %0d want %0d", i, count, exp);
            end
        end
    endtask

    task automatic test_load_priority();
        @(negedge clk);
        load = 1'b1; mode = 1'b0; a = 4'd3;
        step();
        total++;
        if (count !== 4'd3) begin
            bad++;
            $display("FAIL prio_load3: got %0d want 3", count);
        end
        @(negedge clk);
        load = 1'b1; mode = 1'b1; a = 4'd9;
        step();
        total++;
        if (count !== 4'd9) begin
            bad++;
            $display("FAIL prio_load9: got %0d want 9", count);
        end
        @(negedge clk);
        load = 1'b0; mode = 1'b0; a = 4'd0;
        step();
        total++;
        if (count !== 4'd10) begin
            bad++;
            $display("FAIL prio_after_load: got %0d want 10", count);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        load = 1'b1; mode = 1'b0; a = 4'd5;
        step();
        @(negedge clk);
        load = 1'b0;
        step();
        total++;
        if (count !== 4'd6) begin
            bad++;
            $display("FAIL arst_pre: got %0d want 6", count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("FAIL arst_immediate: got %0d want 0", count);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (count !== 4'd0) begin
                bad++;
                $display("FAIL arst_hold%0d: got %0d want 0", i, count);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        total++;
        if (count !== 4'd1) begin
            bad++;
            $display("FAIL arst_release: got %0d want 1", count);
        end
    endtask

    task automatic test_direction_change();
        logic [3:0] exp_seq [3];
        logic       mode_seq [3];
        exp_seq[0] = 4'd4; exp_seq[1] = 4'd3; exp_seq[2] = 4'd4;
        mode_seq[0] = 1'b1; mode_seq[1] = 1'b1; mode_seq[2] = 1'b0;
        @(negedge clk);
        load = 1'b1; mode = 1'b0; a = 4'd4;
        step();
        @(negedge clk);
        load = 1'b0; mode = 1'b0;
        step();
        total++;
        if (count !== 4'd5) begin
            bad++;
            $display("FAIL dir_at5: got %0d want 5", count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mode = mode_seq[i];
            step();
            total++;
            if (count !== exp_seq[i]) begin
                bad++;
                $display("FAIL dir_step%0d: got %0d want %0d", i, count, exp_seq[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_priority();
        test_async_reset();
        test_direction_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
